// File: rtl/deser_pkg.sv
// Shared types and helpers for the symbol deserializer.
// Provides the FSM state type, counter width helper and slot index mapping.
package deser_pkg;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    // Width needed to hold the values 0..n
    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

    // Symbol position inside the word for the k-th received symbol
    function automatic int slot_idx(input int k, input int n, input int msb_first);
        return (msb_first != 0) ? (n - 1 - k) : k;
    endfunction

endpackage

// File: rtl/deser_out_slot.sv
// One-word output register with valid/ready hold behaviour.
// Ports: clk, reset, load/load_data/load_count (from assembler), out_* (to sink).
module deser_out_slot #(
    parameter int W  = 24,
    parameter int CW = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic [W-1:0]  load_data,
    input  logic [CW-1:0] load_count,
    output logic [W-1:0]  out_data,
    output logic [CW-1:0] out_count,
    output logic          out_valid,
    input  logic          out_ready
);

    // load is only raised when the slot is free, so it may overwrite a
    // word that is being drained in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_count <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= load_data;
            out_count <= load_count;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/symbol_deserializer.sv
// Packs NUM_SYM symbols of SYM_W bits into one word with valid/ready on both sides.
// Ports: clk, reset, in_data/in_valid/in_ready, flush, out_data/out_count/out_valid/out_ready.
// Optional: define DESER_WORD_CNT_EN to add word_cnt[31:0] (count of output handshakes).
module symbol_deserializer
    import deser_pkg::*;
#(
    parameter int SYM_W     = 4,
    parameter int NUM_SYM   = 6,
    parameter int MSB_FIRST = 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [SYM_W-1:0]             in_data,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         flush,
    output logic [SYM_W*NUM_SYM-1:0]     out_data,
    output logic [cnt_w(NUM_SYM)-1:0]    out_count,
    output logic                         out_valid,
    input  logic                         out_ready
`ifdef DESER_WORD_CNT_EN
    ,
    output logic [31:0]                  word_cnt
`endif
);

    localparam int W  = SYM_W * NUM_SYM;
    localparam int CW = cnt_w(NUM_SYM);

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [CW-1:0] hcnt, hcnt_n;
    logic [W-1:0]  asm_q, asm_n;
    logic [W-1:0]  wr;
    logic [CW-1:0] fill_n;
    logic          accept, slot_free, emit;
    logic          load;
    logic [W-1:0]  load_data;
    logic [CW-1:0] load_count;

    assign in_ready  = (state == FILL);
    assign accept    = in_valid && in_ready;
    assign slot_free = !out_valid || out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FILL;
            cnt   <= '0;
            hcnt  <= '0;
            asm_q <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            hcnt  <= hcnt_n;
            asm_q <= asm_n;
        end
    end

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        hcnt_n     = hcnt;
        asm_n      = asm_q;
        load       = 1'b0;
        load_data  = asm_q;
        load_count = hcnt;
        wr         = asm_q;
        for (int i = 0; i < NUM_SYM; i++) begin
            if (accept && cnt == CW'(i))
                wr[slot_idx(i, NUM_SYM, MSB_FIRST)*SYM_W +: SYM_W] = in_data;
        end
        fill_n = cnt + CW'(accept);
        // A word leaves assembly when it fills up, or on a flush that has
        // at least one symbol to send (held or arriving this cycle).
        emit = (accept && cnt == CW'(NUM_SYM - 1))
            || (flush && (cnt != '0 || accept));
        unique case (state)
            FILL: begin
                if (emit) begin
                    cnt_n = '0;
                    if (slot_free) begin
                        load       = 1'b1;
                        load_data  = wr;
                        load_count = fill_n;
                        asm_n      = '0;
                    end else begin
                        state_n = HOLD;
                        asm_n   = wr;
                        hcnt_n  = fill_n;
                    end
                end else begin
                    asm_n = wr;
                    cnt_n = (cnt > CW'(NUM_SYM - 1)) ? '0 : fill_n;
                end
            end
            HOLD: begin
                if (slot_free) begin
                    load    = 1'b1;
                    asm_n   = '0;
                    state_n = FILL;
                end
            end
            default: state_n = FILL;
        endcase
    end

    deser_out_slot #(
        .W  (W),
        .CW (CW)
    ) u_slot (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .load_data  (load_data),
        .load_count (load_count),
        .out_data   (out_data),
        .out_count  (out_count),
        .out_valid  (out_valid),
        .out_ready  (out_ready)
    );

`ifdef DESER_WORD_CNT_EN
    always_ff @(posedge clk) begin
        if (reset)
            word_cnt <= '0;
        else if (out_valid && out_ready)
            word_cnt <= word_cnt + 32'd1;
    end
`endif

endmodule

// File: tb/tb_symbol_deserializer.sv
// Directed self-checking bench for symbol_deserializer.
// Runs an MSB-first and an LSB-first instance side by side on the same stimulus.
module tb_symbol_deserializer;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  in_data;
    logic        in_valid;
    logic        flush;
    logic        out_ready;
    logic        in_ready_m, in_ready_l;
    logic [23:0] out_data_m, out_data_l;
    logic [2:0]  out_count_m, out_count_l;
    logic        out_valid_m, out_valid_l;
`ifdef DESER_WORD_CNT_EN
    logic [31:0] word_cnt_m, word_cnt_l;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    symbol_deserializer #(.SYM_W(4), .NUM_SYM(6), .MSB_FIRST(1)) dut_m (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready_m),
        .flush     (flush),
        .out_data  (out_data_m),
        .out_count (out_count_m),
        .out_valid (out_valid_m),
        .out_ready (out_ready)
`ifdef DESER_WORD_CNT_EN
        ,
        .word_cnt  (word_cnt_m)
`endif
    );

    symbol_deserializer #(.SYM_W(4), .NUM_SYM(6), .MSB_FIRST(0)) dut_l (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready_l),
        .flush     (flush),
        .out_data  (out_data_l),
        .out_count (out_count_l),
        .out_valid (out_valid_l),
        .out_ready (out_ready)
`ifdef DESER_WORD_CNT_EN
        ,
        .word_cnt  (word_cnt_l)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present a symbol and advance to the next falling edge.
    task automatic send(input logic [3:0] s);
        in_valid = 1'b1;
        in_data  = s;
        @(negedge clk);
    endtask

    task automatic idle();
        in_valid = 1'b0;
        flush    = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        flush    = 1'b0;
        reset    = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        in_data   = '0;
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        reset     = 1'b1;
        @(negedge clk);
        do_reset();

        // Reset state
        chk("rst_valid", 32'(out_valid_m), 32'h0);
        chk("rst_data", 32'(out_data_m), 32'h0);
        chk("rst_count", 32'(out_count_m), 32'h0);
        chk("rst_in_ready", 32'(in_ready_m), 32'h1);

        // 1: back-to-back 1..6, sink always ready
        for (int k = 1; k <= 5; k++) send(4'(k));
        chk("t1_not_yet", 32'(out_valid_m), 32'h0);
        send(4'h6);
        chk("t1_valid", 32'(out_valid_m), 32'h1);
        chk("t1_data", 32'(out_data_m), 32'h123456);
        chk("t1_count", 32'(out_count_m), 32'h6);
        chk("t1_lsb_data", 32'(out_data_l), 32'h654321);
        idle();
        chk("t1_drained", 32'(out_valid_m), 32'h0);

        // 2: backpressure, 12 symbols with sink stalled
        out_ready = 1'b0;
        for (int k = 1; k <= 12; k++) send(4'(k));
        chk("t2_in_ready_low", 32'(in_ready_m), 32'h0);
        chk("t2_first_word", 32'(out_data_m), 32'h123456);
        idle();
        idle();
        chk("t2_hold_data", 32'(out_data_m), 32'h123456);
        chk("t2_hold_valid", 32'(out_valid_m), 32'h1);
        chk("t2_still_blocked", 32'(in_ready_m), 32'h0);
        out_ready = 1'b1;
        @(negedge clk);
        chk("t2_second_word", 32'(out_data_m), 32'h789ABC);
        chk("t2_second_valid", 32'(out_valid_m), 32'h1);
        chk("t2_second_count", 32'(out_count_m), 32'h6);
        chk("t2_in_ready_back", 32'(in_ready_m), 32'h1);
        @(negedge clk);
        chk("t2_drained", 32'(out_valid_m), 32'h0);

        // 3: partial word flush, then a clean full word
        send(4'hA);
        send(4'hB);
        send(4'hC);
        in_valid = 1'b0;
        flush    = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("t3_flush_valid", 32'(out_valid_m), 32'h1);
        chk("t3_flush_data", 32'(out_data_m), 32'hABC000);
        chk("t3_flush_count", 32'(out_count_m), 32'h3);
        for (int k = 1; k <= 6; k++) send(4'(k));
        chk("t3_next_data", 32'(out_data_m), 32'h123456);
        chk("t3_next_count", 32'(out_count_m), 32'h6);
        idle();

        // 4: reset mid-word discards the partial data
        for (int k = 1; k <= 4; k++) send(4'(k));
        in_valid = 1'b0;
        reset    = 1'b1;
        @(negedge clk);
        chk("t4_rst_valid", 32'(out_valid_m), 32'h0);
        chk("t4_rst_data", 32'(out_data_m), 32'h0);
        reset = 1'b0;
        for (int k = 1; k <= 6; k++) send(4'(k));
        chk("t4_clean_data", 32'(out_data_m), 32'h123456);
        chk("t4_clean_valid", 32'(out_valid_m), 32'h1);
        idle();

        // 5: LSB-first packing and partial flush
        send(4'h1);
        send(4'h2);
        in_valid = 1'b0;
        flush    = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("t5_lsb_data", 32'(out_data_l), 32'h000021);
        chk("t5_lsb_count", 32'(out_count_l), 32'h2);
        chk("t5_msb_data", 32'(out_data_m), 32'h120000);
        idle();

        // 6: flush corner cases
        do_reset();
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("t6_empty_flush", 32'(out_valid_m), 32'h0);
        for (int k = 1; k <= 5; k++) send(4'(k));
        flush = 1'b1;
        send(4'h6);
        flush = 1'b0;
        chk("t6_conc_valid", 32'(out_valid_m), 32'h1);
        chk("t6_conc_count", 32'(out_count_m), 32'h6);
        chk("t6_conc_data", 32'(out_data_m), 32'h123456);
        idle();
        chk("t6_single_word", 32'(out_valid_m), 32'h0);
        idle();
        chk("t6_no_extra", 32'(out_valid_m), 32'h0);
`ifdef DESER_WORD_CNT_EN
        chk("t6_word_cnt", word_cnt_m, 32'h1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
